hazard_scoreboard: RTL and testbench

- Parametrised N-issue successor to the dual-issue hazard detection unit in the ID stage.
- Tracks in-flight loads per architectural register with a multi-cycle load-latency scoreboard.
- Resolves intra-bundle RAW/WAW dependencies and grants in-order partial issue: the oldest independent prefix proceeds, the rest are held.
- Drives per-slot stall/flush masks in the existing PIPE_REG_* format and keeps a saturating stall-cycle counter.

---
 rtl/hazard_scoreboard_if.sv | 29 ++
 rtl/hazard_scoreboard.sv | 88 ++++++++
 tb/tb_hazard_scoreboard.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-slot bundle, hold and issue/mask results shared between ID and the scoreboard
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`define PIPE_REG_PC 1
`define PIPE_REG_IF_ID 2
`define PIPE_REG_ID_EX 4
`define PIPE_REG_EX_MEM 8
`define PIPE_REG_MEM_WB 16
`endif
interface hazard_scoreboard_if #(
  parameter int ISSUE_WIDTH = 2,
  parameter int REG_BITS = 5,
  parameter int STAT_BITS = 16
);
  logic hold;
  logic [ISSUE_WIDTH-1:0] slot_valid, slot_dst_en, slot_is_load, issue_grant;
  logic [ISSUE_WIDTH*REG_BITS-1:0] slot_rs, slot_rt, slot_dst;
  logic [ISSUE_WIDTH*2-1:0] slot_src_mask;
  logic [ISSUE_WIDTH*`NUM_PIPE_MASKS-1:0] stall, flush;
  logic [STAT_BITS-1:0] stall_cycles;
  modport master (
    output hold, slot_valid, slot_rs, slot_rt, slot_dst, slot_src_mask, slot_dst_en, slot_is_load,
    input issue_grant, stall, flush, stall_cycles
  );
  modport slave (
    input hold, slot_valid, slot_rs, slot_rt, slot_dst, slot_src_mask, slot_dst_en, slot_is_load,
    output issue_grant, stall, flush, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: N-issue load-use scoreboard with in-order partial issue and per-slot pipeline masks
module hazard_scoreboard #(
  parameter int ISSUE_WIDTH = 2,
  parameter int REG_BITS = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int STAT_BITS = 16
) (
  input logic clk,
  input logic reset,
  hazard_scoreboard_if.slave bus
);
  localparam int NR = 1 << REG_BITS;
  localparam int CB = $clog2(LOAD_LATENCY + 1);
  localparam int NM = `NUM_PIPE_MASKS;
  localparam logic [NM-1:0] M_HELD = NM'(`PIPE_REG_PC | `PIPE_REG_IF_ID);
  localparam logic [NM-1:0] M_PC = NM'(`PIPE_REG_PC);
  localparam logic [NM-1:0] M_IFID = NM'(`PIPE_REG_IF_ID);
  localparam logic [NM-1:0] M_IDEX = NM'(`PIPE_REG_ID_EX);
  logic [CB-1:0] busy_q [NR];
  logic [CB-1:0] busy_d [NR];
  logic [STAT_BITS-1:0] stall_cycles_q, stall_cycles_d;
  logic [ISSUE_WIDTH-1:0] grant, waiting;
  logic [ISSUE_WIDTH*NM-1:0] stall_m, flush_m;
  logic partial;
  always_comb begin
    logic [REG_BITS-1:0] rs, rt, dk, di;
    logic rd_rs, rd_rt, blk, in_order;
    rs = '0;
    rt = '0;
    dk = '0;
    di = '0;
    rd_rs = 1'b0;
    rd_rt = 1'b0;
    blk = 1'b0;
    in_order = 1'b1;
    grant = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      rs = bus.slot_rs[k*REG_BITS +: REG_BITS];
      rt = bus.slot_rt[k*REG_BITS +: REG_BITS];
      dk = bus.slot_dst[k*REG_BITS +: REG_BITS];
      rd_rs = bus.slot_src_mask[2*k] && rs != '0;
      rd_rt = bus.slot_src_mask[2*k+1] && rt != '0;
      blk = !in_order || (rd_rs && busy_q[rs] != '0) || (rd_rt && busy_q[rt] != '0);
      // no same-cycle forwarding between slots, so any older writer of a source or of our dst holds us
      for (int i = 0; i < k; i++) begin
        di = bus.slot_dst[i*REG_BITS +: REG_BITS];
        blk = blk || (bus.slot_valid[i] && bus.slot_dst_en[i] && di != '0 &&
              ((rd_rs && di == rs) || (rd_rt && di == rt) || (bus.slot_dst_en[k] && di == dk)));
      end
      grant[k] = bus.slot_valid[k] && !blk && !bus.hold;
      in_order = in_order && !(bus.slot_valid[k] && !grant[k]);
    end
  end
  assign waiting = bus.slot_valid & ~grant;
  assign partial = !bus.hold && |waiting;
  always_comb begin
    stall_m = '0;
    flush_m = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      stall_m[k*NM +: NM] = (bus.hold || waiting[k]) ? M_HELD : (grant[k] && partial) ? M_PC : '0;
      flush_m[k*NM +: NM] = bus.hold ? '0 : waiting[k] ? M_IDEX : (grant[k] && partial) ? M_IFID : '0;
    end
  end
  always_comb begin
    busy_d = busy_q;
    stall_cycles_d = stall_cycles_q;
    if (!bus.hold) begin
      for (int r = 0; r < NR; r++)
        busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - CB'(1) : '0;
      for (int k = 0; k < ISSUE_WIDTH; k++)
        if (grant[k] && bus.slot_is_load[k] && bus.slot_dst[k*REG_BITS +: REG_BITS] != '0)
          busy_d[bus.slot_dst[k*REG_BITS +: REG_BITS]] = CB'(LOAD_LATENCY);
      stall_cycles_d = (partial && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy_q <= '{default: '0};
      stall_cycles_q <= '0;
    end else begin
      busy_q <= busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  assign bus.issue_grant = reset ? '0 : grant;
  assign bus.stall = reset ? '0 : stall_m;
  assign bus.flush = reset ? '0 : flush_m;
  assign bus.stall_cycles = reset ? '0 : stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for a 2-wide/latency-1 and a 4-wide/latency-3 instance
module tb_hazard_scoreboard;
  localparam int PC = `PIPE_REG_PC;
  localparam int IFID = `PIPE_REG_IF_ID;
  localparam int IDEX = `PIPE_REG_ID_EX;
  localparam int HS = PC | IFID;
  typedef struct {
    string tag;
    bit w4;
    logic [3:0] g;
    logic [19:0] s, f;
    logic [15:0] c;
  } exp_t;
  logic clk = 1'b0, reset, hold2, hold4;
  logic [3:0] v, den, ld;
  logic [19:0] rs, rt, dst;
  logic [7:0] msk;
  int n_cmp = 0, n_bad = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.ISSUE_WIDTH(2)) i2();
  hazard_scoreboard_if #(.ISSUE_WIDTH(4)) i4();
  assign i2.hold = hold2;
  assign i2.slot_valid = v[1:0];
  assign i2.slot_rs = rs[9:0];
  assign i2.slot_rt = rt[9:0];
  assign i2.slot_dst = dst[9:0];
  assign i2.slot_src_mask = msk[3:0];
  assign i2.slot_dst_en = den[1:0];
  assign i2.slot_is_load = ld[1:0];
  assign i4.hold = hold4;
  assign i4.slot_valid = v;
  assign i4.slot_rs = rs;
  assign i4.slot_rt = rt;
  assign i4.slot_dst = dst;
  assign i4.slot_src_mask = msk;
  assign i4.slot_dst_en = den;
  assign i4.slot_is_load = ld;
  hazard_scoreboard #(.ISSUE_WIDTH(2), .LOAD_LATENCY(1)) u2 (.clk(clk), .reset(reset), .bus(i2));
  hazard_scoreboard #(.ISSUE_WIDTH(4), .LOAD_LATENCY(3)) u4 (.clk(clk), .reset(reset), .bus(i4));
  function automatic logic [19:0] mk(int a, int b = 0, int c = 0, int d = 0);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clr();
    v = '0; den = '0; ld = '0; rs = '0; rt = '0; dst = '0; msk = '0;
  endtask
  task automatic slot(int k, int r_s, int r_t, int m, int d, bit de, bit l);
    v[k] = 1'b1;
    rs[k*5 +: 5] = 5'(r_s);
    rt[k*5 +: 5] = 5'(r_t);
    msk[k*2 +: 2] = 2'(m);
    dst[k*5 +: 5] = 5'(d);
    den[k] = de;
    ld[k] = l;
  endtask
  task automatic push(string tag, bit w4, logic [3:0] g, logic [19:0] s, logic [19:0] f, logic [15:0] c);
    q.push_back('{tag: tag, w4: w4, g: g, s: s, f: f, c: c});
  endtask
  task automatic pop_all();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.w4) begin
        chk({e.tag, ".grant"}, 32'(i4.issue_grant), 32'(e.g));
        chk({e.tag, ".stall"}, 32'(i4.stall), 32'(e.s));
        chk({e.tag, ".flush"}, 32'(i4.flush), 32'(e.f));
        chk({e.tag, ".cycles"}, 32'(i4.stall_cycles), 32'(e.c));
      end else begin
        chk({e.tag, ".grant"}, 32'(i2.issue_grant), 32'(e.g));
        chk({e.tag, ".stall"}, 32'(i2.stall), 32'(e.s));
        chk({e.tag, ".flush"}, 32'(i2.flush), 32'(e.f));
        chk({e.tag, ".cycles"}, 32'(i2.stall_cycles), 32'(e.c));
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    pop_all();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; hold2 = 1'b0; hold4 = 1'b0;
    clr(); slot(0, 1, 2, 3, 6, 1, 0);
    push("rst2", 0, 0, 0, 0, 0); push("rst4", 1, 0, 0, 0, 0);
    step();
    reset = 1'b0; hold4 = 1'b1;
    clr(); slot(0, 1, 0, 1, 5, 1, 1);
    push("a0_lw", 0, 4'b01, 0, 0, 0); step();
    clr(); slot(0, 5, 2, 3, 6, 1, 0);
    push("a1_use", 0, 4'b00, mk(HS), mk(IDEX), 0); step();
    push("a2_go", 0, 4'b01, 0, 0, 1); step();
    clr(); slot(0, 1, 0, 1, 3, 1, 0); slot(1, 3, 2, 3, 8, 1, 0);
    push("b0_raw", 0, 4'b01, mk(PC, HS), mk(IFID, IDEX), 1); step();
    clr(); slot(0, 3, 2, 3, 8, 1, 0);
    push("b1_next", 0, 4'b01, 0, 0, 2); step();
    clr(); slot(0, 1, 2, 3, 0, 1, 0); slot(1, 0, 0, 3, 9, 1, 0);
    push("c0_r0", 0, 4'b11, 0, 0, 2); step();
    clr(); slot(0, 1, 2, 3, 7, 1, 0); slot(1, 3, 4, 3, 7, 1, 0);
    push("c1_waw", 0, 4'b01, mk(PC, HS), mk(IFID, IDEX), 2); step();
    hold2 = 1'b1; hold4 = 1'b0;
    clr(); slot(0, 1, 0, 1, 9, 1, 1); slot(1, 2, 3, 3, 10, 1, 0);
    push("d0_lw", 1, 4'b0011, 0, 0, 0); step();
    clr(); slot(0, 9, 2, 3, 11, 1, 0); slot(1, 2, 3, 3, 12, 1, 0); slot(2, 4, 5, 3, 13, 1, 0);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("d_wait%0d", i), 1, 4'b0000, mk(HS, HS, HS), mk(IDEX, IDEX, IDEX), 16'(i));
      step();
    end
    push("d_go", 1, 4'b0111, 0, 0, 3); step();
    clr(); slot(0, 1, 2, 3, 16, 1, 0); slot(1, 2, 3, 3, 14, 1, 0); slot(2, 14, 0, 1, 17, 1, 0); slot(3, 1, 1, 3, 18, 1, 0);
    push("d5_mid", 1, 4'b0011, mk(PC, PC, HS, HS), mk(IFID, IFID, IDEX, IDEX), 3); step();
    clr(); slot(0, 1, 0, 1, 4, 1, 1);
    push("e0_lw", 1, 4'b0001, 0, 0, 4); step();
    hold4 = 1'b1;
    clr(); slot(0, 4, 0, 1, 15, 1, 0);
    for (int i = 0; i < 2; i++) begin
      push($sformatf("e_hold%0d", i), 1, 4'b0000, mk(HS, HS, HS, HS), 0, 4);
      step();
    end
    hold4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("e_wait%0d", i), 1, 4'b0000, mk(HS), mk(IDEX), 16'(4 + i));
      step();
    end
    push("e_go", 1, 4'b0001, 0, 0, 7); step();
    hold4 = 1'b1; hold2 = 1'b0;
    clr(); slot(0, 1, 2, 3, 7, 1, 0); slot(1, 3, 4, 3, 7, 1, 0);
    push("f0_waw", 0, 4'b01, mk(PC, HS), mk(IFID, IDEX), 3); step();
    clr(); slot(0, 1, 0, 1, 6, 1, 1); slot(1, 2, 3, 3, 6, 1, 0);
    push("f1_lw", 0, 4'b01, mk(PC, HS), mk(IFID, IDEX), 4); step();
    clr(); slot(0, 6, 0, 1, 8, 1, 0);
    push("f2_busy", 0, 4'b00, mk(HS), mk(IDEX), 5);
    @(negedge clk);
    pop_all();
    reset = 1'b1;
    #1;
    push("f_rst2", 0, 0, 0, 0, 0); push("f_rst4", 1, 0, 0, 0, 0);
    pop_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push("f3_first", 0, 4'b01, 0, 0, 0); step();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover expectations got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
